// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared types and constants for the two-requester byte
//               memory arbiter (FSM encoding, requester identifiers).
// Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    // Arbiter FSM: sample requests, drive the strobe for one cycle, then ack.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Requester identifiers; also used as the value of owner/last registers.
    localparam logic c_req_a = 1'b0;
    localparam logic c_req_b = 1'b1;

endpackage : memory_arbiter_pkg
`default_nettype wire

// File: rtl/memory_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker with owner lock.
//               A locked owner that is still requesting keeps the grant;
//               otherwise a tie goes to the requester that was not served
//               last, and a single request wins outright.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import memory_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic locked,
    input  logic owner,
    output logic valid,
    output logic winner
);

    logic w_owner_req;

    // Request line of whoever currently owns the memory.
    assign w_owner_req = (owner == c_req_a) ? req_a : req_b;

    // Priority: live lock, then strict alternation on a tie, then lone request.
    always_comb begin
        valid  = req_a | req_b;
        winner = c_req_a;
        if (locked && w_owner_req) begin
            winner = owner;
        end else if (req_a && req_b) begin
            winner = ~last;
        end else if (req_b) begin
            winner = c_req_b;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one single-port byte memory (registered 1-cycle read)
//               between requesters A and B. One byte per req/ack handshake,
//               round-robin arbitration with an optional per-requester lock.
//               All outputs are registered or decoded from state, except
//               rdata which is wired straight from the memory.
//               Note for integration: if both sides hold lock and req
//               continuously, the current owner keeps the grant and the
//               other side starves; preventing that is the callers' job.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_byte,
    input  logic [DATA_WIDTH-1:0] mem_read_byte
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_owner;
    logic                  r_last;
    logic                  r_locked;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_write_byte;
    logic                  r_a_ack;
    logic                  r_b_ack;

    logic                  w_valid;
    logic                  w_winner;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_owner_req;
    logic                  w_owner_lock;

    rr_pick2 u_pick (
        .req_a  (a_req),
        .req_b  (b_req),
        .last   (r_last),
        .locked (r_locked),
        .owner  (r_owner),
        .valid  (w_valid),
        .winner (w_winner)
    );

    // Request fields of the winner, captured only in IDLE.
    assign w_sel_we    = (w_winner == c_req_b) ? b_we    : a_we;
    assign w_sel_addr  = (w_winner == c_req_b) ? b_addr  : a_addr;
    assign w_sel_wdata = (w_winner == c_req_b) ? b_wdata : a_wdata;

    // Live req/lock of the registered owner.
    assign w_owner_req  = (r_owner == c_req_b) ? b_req  : a_req;
    assign w_owner_lock = (r_owner == c_req_b) ? b_lock : a_lock;

    assign a_ack          = r_a_ack;
    assign b_ack          = r_b_ack;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_addr       = r_mem_addr;
    assign mem_write_byte = r_mem_write_byte;
    assign busy           = (r_state != ST_IDLE);
    assign rdata          = mem_read_byte;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: IDLE -> ACCESS on any request, then DONE, then back to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Datapath, strobes, acks and arbitration history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_write_byte <= '0;
            r_a_ack          <= 1'b0;
            r_b_ack          <= 1'b0;
            r_last           <= c_req_b;
            r_locked         <= 1'b0;
            r_owner          <= c_req_a;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A lock only survives while its owner keeps requesting.
                    if (r_locked && !w_owner_req) begin
                        r_locked <= 1'b0;
                    end
                    if (w_valid) begin
                        r_owner          <= w_winner;
                        r_mem_read       <= ~w_sel_we;
                        r_mem_write      <= w_sel_we;
                        r_mem_addr       <= w_sel_addr;
                        r_mem_write_byte <= w_sel_wdata;
                    end
                end
                ST_ACCESS: begin
                    // Memory acts on this edge; the ack lands with read data.
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_a_ack     <= (r_owner == c_req_a);
                    r_b_ack     <= (r_owner == c_req_b);
                end
                ST_DONE: begin
                    r_last   <= r_owner;
                    r_locked <= w_owner_lock;
                end
                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule : memory_arbiter
`default_nettype wire
